// File: rtl/mips_pkg.sv
// Shared control-bundle layout and opcode constants for the 5-stage MIPS core.
package mips_pkg;

  localparam int unsigned EX_W = 4;
  localparam int unsigned M_W  = 3;
  localparam int unsigned WB_W = 2;

  localparam int unsigned EX_REGDST   = 3;
  localparam int unsigned EX_ALUOP_HI = 2;
  localparam int unsigned EX_ALUOP_LO = 1;
  localparam int unsigned EX_ALUSRC   = 0;

  localparam int unsigned M_BRANCH   = 2;
  localparam int unsigned M_MEMREAD  = 1;
  localparam int unsigned M_MEMWRITE = 0;

  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;

  // NOP shares the R-type encoding (sll $0,$0,0), so these stay plain constants
  localparam logic [5:0] RTYPE = 6'h00;
  localparam logic [5:0] LW    = 6'h23;
  localparam logic [5:0] SW    = 6'h2B;
  localparam logic [5:0] BEQ   = 6'h04;
  localparam logic [5:0] NOP   = 6'h00;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds the decode instruction.
module hazard_detect #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  valid,
  input  logic                  mem_read,
  input  logic [REG_ADDR_W-1:0] rt_ex,
  input  logic [REG_ADDR_W-1:0] rs_id,
  input  logic [REG_ADDR_W-1:0] rt_id,
  output logic                  hazard
);

  always_comb begin
    hazard = valid & mem_read & (|rt_ex) & ((rt_ex == rs_id) | (rt_ex == rt_id));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and branch flush.
// Optional stall counter enabled by defining HAZARD_CNT_EN.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [EX_W-1:0]       ex_i,
  input  logic [M_W-1:0]        m_i,
  input  logic [WB_W-1:0]       wb_i,
  input  logic [DATA_W-1:0]     npc_i,
  input  logic [DATA_W-1:0]     rd_data1_i,
  input  logic [DATA_W-1:0]     rd_data2_i,
  input  logic [DATA_W-1:0]     imm_i,
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [REG_ADDR_W-1:0] rt_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  flush_i,
  output logic [EX_W-1:0]       ex_o,
  output logic [M_W-1:0]        m_o,
  output logic [WB_W-1:0]       wb_o,
  output logic [DATA_W-1:0]     npc_o,
  output logic [DATA_W-1:0]     rd_data1_o,
  output logic [DATA_W-1:0]     rd_data2_o,
  output logic [DATA_W-1:0]     imm_o,
  output logic [REG_ADDR_W-1:0] rs_o,
  output logic [REG_ADDR_W-1:0] rt_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  valid_o,
  output logic                  stall_o
`ifdef HAZARD_CNT_EN
  ,
  output logic [31:0]           stall_cnt_o
`endif
);

  logic hazard;
  logic bubble;

  hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard_detect (
    .valid    (valid_o),
    .mem_read (m_o[M_MEMREAD]),
    .rt_ex    (rt_o),
    .rs_id    (rs_i),
    .rt_id    (rt_i),
    .hazard   (hazard)
  );

  always_comb begin
    stall_o = hazard & ~flush_i;
    bubble  = flush_i | hazard;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_o       <= '0;
      m_o        <= '0;
      wb_o       <= '0;
      npc_o      <= '0;
      rd_data1_o <= '0;
      rd_data2_o <= '0;
      imm_o      <= '0;
      rs_o       <= '0;
      rt_o       <= '0;
      rd_o       <= '0;
      valid_o    <= 1'b0;
    end else begin
      npc_o      <= npc_i;
      rd_data1_o <= rd_data1_i;
      rd_data2_o <= rd_data2_i;
      imm_o      <= imm_i;
      rs_o       <= rs_i;
      rt_o       <= rt_i;
      rd_o       <= rd_i;
      // Only control is squashed; datapath fields are ignored while valid_o=0
      if (bubble) begin
        ex_o    <= '0;
        m_o     <= '0;
        wb_o    <= '0;
        valid_o <= 1'b0;
      end else begin
        ex_o    <= ex_i;
        m_o     <= m_i;
        wb_o    <= wb_i;
        valid_o <= 1'b1;
      end
    end
  end

`ifdef HAZARD_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
    end else if (stall_o && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (stall counter checked when HAZARD_CNT_EN is defined).
module tb_id_ex_stage;
  import mips_pkg::*;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [EX_W-1:0]       ex_i;
  logic [M_W-1:0]        m_i;
  logic [WB_W-1:0]       wb_i;
  logic [DATA_W-1:0]     npc_i, rd_data1_i, rd_data2_i, imm_i;
  logic [REG_ADDR_W-1:0] rs_i, rt_i, rd_i;
  logic                  flush_i;
  logic [EX_W-1:0]       ex_o;
  logic [M_W-1:0]        m_o;
  logic [WB_W-1:0]       wb_o;
  logic [DATA_W-1:0]     npc_o, rd_data1_o, rd_data2_o, imm_o;
  logic [REG_ADDR_W-1:0] rs_o, rt_o, rd_o;
  logic                  valid_o, stall_o;
`ifdef HAZARD_CNT_EN
  logic [31:0]           stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(
    .DATA_W    (DATA_W),
    .REG_ADDR_W(REG_ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_i       (ex_i),
    .m_i        (m_i),
    .wb_i       (wb_i),
    .npc_i      (npc_i),
    .rd_data1_i (rd_data1_i),
    .rd_data2_i (rd_data2_i),
    .imm_i      (imm_i),
    .rs_i       (rs_i),
    .rt_i       (rt_i),
    .rd_i       (rd_i),
    .flush_i    (flush_i),
    .ex_o       (ex_o),
    .m_o        (m_o),
    .wb_o       (wb_o),
    .npc_o      (npc_o),
    .rd_data1_o (rd_data1_o),
    .rd_data2_o (rd_data2_o),
    .imm_o      (imm_o),
    .rs_o       (rs_o),
    .rt_o       (rt_o),
    .rd_o       (rd_o),
    .valid_o    (valid_o),
    .stall_o    (stall_o)
`ifdef HAZARD_CNT_EN
    ,
    .stall_cnt_o(stall_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] ex, input logic [2:0] m, input logic [1:0] wb,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    ex_i = ex; m_i = m; wb_i = wb;
    rs_i = rs; rt_i = rt; rd_i = rd;
  endtask

  // Control encodings: {RegDst,ALUOp,ALUSrc} / {Branch,MemRead,MemWrite} / {RegWrite,MemtoReg}
  localparam logic [3:0] EX_R  = 4'b1100;
  localparam logic [3:0] EX_LS = 4'b0001;

  initial begin
    rst_n = 1'b0; flush_i = 1'b0;
    npc_i = '0; rd_data1_i = '0; rd_data2_i = '0; imm_i = '0;
    present('0, '0, '0, '0, '0, '0);
    #1;
    check("rst_ex", 32'(ex_o), 32'h0);
    check("rst_m", 32'(m_o), 32'h0);
    check("rst_wb", 32'(wb_o), 32'h0);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_stall", 32'(stall_o), 32'h0);
    #1 rst_n = 1'b1;

    // R-type passes straight through
    present(EX_R, 3'b000, 2'b10, 5'd1, 5'd2, 5'd3);
    rd_data1_i = 32'h5; rd_data2_i = 32'h7; imm_i = 32'hFFFF_FFF0; npc_i = 32'h104;
    tick();
    check("rt_ex", 32'(ex_o), 32'hC);
    check("rt_m", 32'(m_o), 32'h0);
    check("rt_wb", 32'(wb_o), 32'h2);
    check("rt_rd", 32'(rd_o), 32'h3);
    check("rt_d1", rd_data1_o, 32'h5);
    check("rt_d2", rd_data2_o, 32'h7);
    check("rt_imm", imm_o, 32'hFFFF_FFF0);
    check("rt_npc", npc_o, 32'h104);
    check("rt_valid", 32'(valid_o), 32'h1);
    check("rt_stall", 32'(stall_o), 32'h0);

    // Load-use on rs: one bubble, then the dependent instruction loads
    present(EX_LS, 3'b010, 2'b11, 5'd1, 5'd8, 5'd0);
    tick();
    check("lw_m", 32'(m_o), 32'h2);
    present(EX_R, 3'b000, 2'b10, 5'd8, 5'd9, 5'd10);
    #1;
    check("lu_rs_stall", 32'(stall_o), 32'h1);
    tick();
    check("bub_ex", 32'(ex_o), 32'h0);
    check("bub_m", 32'(m_o), 32'h0);
    check("bub_wb", 32'(wb_o), 32'h0);
    check("bub_valid", 32'(valid_o), 32'h0);
    check("bub_stall", 32'(stall_o), 32'h0);
    tick();
    check("add_ex", 32'(ex_o), 32'hC);
    check("add_rd", 32'(rd_o), 32'hA);
    check("add_valid", 32'(valid_o), 32'h1);

    // Load-use on rt
    present(EX_LS, 3'b010, 2'b11, 5'd2, 5'd8, 5'd0);
    tick();
    present(EX_R, 3'b000, 2'b10, 5'd3, 5'd8, 5'd11);
    #1;
    check("lu_rt_stall", 32'(stall_o), 32'h1);
    tick();
    check("lu_rt_bub_valid", 32'(valid_o), 32'h0);
    tick();
    check("lu_rt_valid", 32'(valid_o), 32'h1);

    // Load into $0 never stalls
    present(EX_LS, 3'b010, 2'b11, 5'd1, 5'd0, 5'd0);
    tick();
    present(EX_R, 3'b000, 2'b10, 5'd0, 5'd0, 5'd12);
    #1;
    check("zero_stall", 32'(stall_o), 32'h0);
    tick();
    check("zero_valid", 32'(valid_o), 32'h1);
    check("zero_ex", 32'(ex_o), 32'hC);

    // Store in EX does not stall
    present(EX_LS, 3'b001, 2'b00, 5'd1, 5'd8, 5'd0);
    tick();
    present(EX_R, 3'b000, 2'b10, 5'd8, 5'd8, 5'd13);
    #1;
    check("sw_stall", 32'(stall_o), 32'h0);
    tick();
    check("sw_valid", 32'(valid_o), 32'h1);

    // Third load-use stall (for the counter)
    present(EX_LS, 3'b010, 2'b11, 5'd1, 5'd5, 5'd0);
    tick();
    present(EX_R, 3'b000, 2'b10, 5'd5, 5'd6, 5'd14);
    #1;
    check("lu3_stall", 32'(stall_o), 32'h1);
    tick();
    check("lu3_bub_valid", 32'(valid_o), 32'h0);
    tick();
    check("lu3_valid", 32'(valid_o), 32'h1);
`ifdef HAZARD_CNT_EN
    check("stall_cnt", stall_cnt_o, 32'd3);
`endif

    // Flush overrides a simultaneous hazard
    present(EX_LS, 3'b010, 2'b11, 5'd1, 5'd8, 5'd0);
    tick();
    present(EX_R, 3'b000, 2'b10, 5'd8, 5'd9, 5'd15);
    flush_i = 1'b1;
    #1;
    check("flush_stall", 32'(stall_o), 32'h0);
    tick();
    check("flush_valid", 32'(valid_o), 32'h0);
    check("flush_ex", 32'(ex_o), 32'h0);
    check("flush_wb", 32'(wb_o), 32'h0);
    // Flush with no hazard still bubbles
    present(EX_R, 3'b000, 2'b10, 5'd1, 5'd2, 5'd3);
    tick();
    check("flush2_valid", 32'(valid_o), 32'h0);
    flush_i = 1'b0;
`ifdef HAZARD_CNT_EN
    check("stall_cnt_flush", stall_cnt_o, 32'd3);
`endif

    // Asynchronous reset in the middle of a stall
    present(EX_LS, 3'b010, 2'b11, 5'd1, 5'd8, 5'd0);
    tick();
    check("pre_rst_valid", 32'(valid_o), 32'h1);
    present(EX_R, 3'b000, 2'b10, 5'd8, 5'd9, 5'd16);
    #1;
    check("pre_rst_stall", 32'(stall_o), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(valid_o), 32'h0);
    check("arst_m", 32'(m_o), 32'h0);
    check("arst_ex", 32'(ex_o), 32'h0);
    check("arst_rt", 32'(rt_o), 32'h0);
    check("arst_stall", 32'(stall_o), 32'h0);
`ifdef HAZARD_CNT_EN
    check("arst_cnt", stall_cnt_o, 32'd0);
`endif
    #1 rst_n = 1'b1;
    tick();
    check("post_rst_valid", 32'(valid_o), 32'h1);
    check("post_rst_ex", 32'(ex_o), 32'hC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
